exc_ctrl: RTL
=============

// Module: exc_ctrl
// PURPOSE
//  Exception/interrupt controller: the consumer of maindec's exception outputs (NotAnInstr, EStatus, ERet)
//  and the source of its ExtIRQ input. Arbitrates external IRQs against invalid-opcode exceptions.
//  Captures ELR/ESR, redirects fetch to the handler vector and returns on ERET.
//  Exposes ELR/ESR/status to the MRS datapath.
// PARAMETERS
//  VECTOR    64'h0000_0000_0000_00D8  handler entry address driven on ExcVector
//  IRQ_CODE  4'b0001                  ESR code written for external interrupts
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  reset        in   1   asynchronous, active-low reset (0 = reset)
//  instr_valid  in   1   an instruction retires this cycle; decoder inputs/PC qualified by it
//  PC           in   64  PC of the retiring instruction
//  NotAnInstr   in   1   from maindec: invalid opcode
//  EStatus      in   4   from maindec: exception code (4'b0010 for invalid opcode)
//  ERet         in   1   from maindec: ERET retiring
//  IRQReq       in   1   external device interrupt request, level, held until IRQAck
//  ExtIRQ       out  1   to maindec: interrupt accepted this cycle (hold-previous-controls strobe)
//  IRQAck       out  1   one-cycle acknowledge to device
//  Exc          out  1   one-cycle redirect: fetch loads ExcVector
//  ExcVector    out  64  = VECTOR (constant)
//  ERetTaken    out  1   one-cycle redirect: fetch loads ELR
//  ELR          out  64  exception link register
//  ESR          out  4   exception syndrome register
//  InHandler    out  1   1 while state is ENTRY or HANDLER
//  DoubleFault  out  1   sticky: exception raised inside handler
//  sysreg_sel   in   2   MRS select: 00 ELR, 01 {60'b0,ESR}, 10 {61'b0,DoubleFault,InHandler,IRQReq}, 11 0
//  sysreg_rdata out  64  combinational read of selected register
// BEHAVIOUR
//  Reset (reset=0, async)
//   - State RUN; ELR=0; ESR=0; DoubleFault=0.
//   - All pulses (ExtIRQ, IRQAck, Exc, ERetTaken) = 0.
//  FSM states: RUN -> ENTRY -> HANDLER -> RET -> RUN.
//  RUN, rising edge with instr_valid=1:
//   - NotAnInstr=1 (priority over IRQ) -> ELR<=PC, ESR<=EStatus, cause=EXC, go ENTRY.
//   - else IRQReq=1 -> ELR<=PC+4 (mod 2^64), ESR<=IRQ_CODE, cause=IRQ, go ENTRY.
//     ExtIRQ=1 combinationally in that same cycle.
//   - else ERet=1 (outside handler) -> treated as invalid: ELR<=PC, ESR<=4'b0100, go ENTRY.
//   - instr_valid=0: no state change; IRQReq stays pending.
//  ENTRY, exactly 1 cycle:
//   - Exc=1; IRQAck=1 iff cause=IRQ; then HANDLER. Entry latency = 1 cycle after detect edge.
//  HANDLER:
//   - IRQs masked; IRQReq is not acked and stays pending.
//   - ERet & instr_valid -> RET.
//   - NotAnInstr & instr_valid -> DoubleFault<=1, ESR<=EStatus, ELR unchanged, go ENTRY.
//  RET, 1 cycle:
//   - ERetTaken=1, ELR stable; then RUN.
//   - A pending IRQ is taken at the first valid RUN edge; no retirement in RET is considered.
//  MRS read in the same cycle as an ELR/ESR update returns the old (pre-edge) value.
//  Reset mid-ENTRY/RET aborts; no Exc/ERetTaken/IRQAck pulse after reset asserts.
//  DoubleFault is cleared only by reset.
// TESTING
//  1. reset, then PC=0x40, NotAnInstr=1, EStatus=2, instr_valid=1 -> next cycle Exc=1, ELR=0x40, ESR=2, InHandler=1.
//  2. IRQReq=1, PC=0x100 valid in RUN -> ExtIRQ=1 same cycle; next cycle IRQAck=Exc=1; ELR=0x104, ESR=1.
//  3. In HANDLER: ERet valid -> next cycle ERetTaken=1, ELR unchanged; following cycle state RUN, InHandler=0.
//  4. IRQReq and NotAnInstr together at PC=0x80 -> ESR=2, ELR=0x80, no IRQAck; IRQ taken after the ERET return.
//  5. NotAnInstr inside HANDLER -> DoubleFault=1, ELR keeps first value, Exc pulses; PC=0xFFFF_FFFF_FFFF_FFFC IRQ -> ELR=0.
//  6. sysreg_sel sweep 00..11 after test 1 -> 0x40, 0x2, 0x2, 0x0; reset asserted during ENTRY -> all outputs 0.

Source files
------------

// File: rtl/exc_ctrl_if.sv
// Decoder/fetch/MRS-facing signal bundle of the exception controller.
// The core side (decoder, fetch, MRS datapath) uses master; exc_ctrl uses slave.
interface exc_ctrl_if;
  logic        instr_valid;
  logic [63:0] PC;
  logic        NotAnInstr;
  logic [3:0]  EStatus;
  logic        ERet;
  logic        IRQReq;
  logic        ExtIRQ;
  logic        IRQAck;
  logic        Exc;
  logic [63:0] ExcVector;
  logic        ERetTaken;
  logic [63:0] ELR;
  logic [3:0]  ESR;
  logic        InHandler;
  logic        DoubleFault;
  logic [1:0]  sysreg_sel;
  logic [63:0] sysreg_rdata;

  modport master (
    output instr_valid, PC, NotAnInstr, EStatus, ERet, IRQReq, sysreg_sel,
    input  ExtIRQ, IRQAck, Exc, ExcVector, ERetTaken, ELR, ESR, InHandler,
           DoubleFault, sysreg_rdata
  );

  modport slave (
    input  instr_valid, PC, NotAnInstr, EStatus, ERet, IRQReq, sysreg_sel,
    output ExtIRQ, IRQAck, Exc, ExcVector, ERetTaken, ELR, ESR, InHandler,
           DoubleFault, sysreg_rdata
  );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller: arbitrates invalid opcodes against external IRQs,
// captures ELR/ESR, redirects fetch to the handler vector and back on ERET.
module exc_ctrl #(
  parameter logic [63:0] VECTOR   = 64'h0000_0000_0000_00D8,
  parameter logic [3:0]  IRQ_CODE = 4'b0001
) (
  input  logic     clk,
  input  logic     reset,
  exc_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, ENTRY, HANDLER, RET} state_t;

  state_t      state, state_n;
  logic [63:0] elr, elr_n;
  logic [3:0]  esr, esr_n;
  logic        df, df_n;
  logic        cause_irq, cause_irq_n;
  logic        ext_irq, irq_ack, exc, eret_taken;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      elr       <= '0;
      esr       <= '0;
      df        <= 1'b0;
      cause_irq <= 1'b0;
    end else begin
      state     <= state_n;
      elr       <= elr_n;
      esr       <= esr_n;
      df        <= df_n;
      cause_irq <= cause_irq_n;
    end
  end

  always_comb begin
    state_n     = state;
    elr_n       = elr;
    esr_n       = esr;
    df_n        = df;
    cause_irq_n = cause_irq;
    ext_irq     = 1'b0;
    irq_ack     = 1'b0;
    exc         = 1'b0;
    eret_taken  = 1'b0;
    case (state)
      RUN: begin
        // ExtIRQ is combinational, so it is also gated by reset to stay silent while held.
        if (reset && bus.instr_valid) begin
          if (bus.NotAnInstr) begin
            elr_n       = bus.PC;
            esr_n       = bus.EStatus;
            cause_irq_n = 1'b0;
            state_n     = ENTRY;
          end else if (bus.IRQReq) begin
            elr_n       = bus.PC + 64'd4;
            esr_n       = IRQ_CODE;
            cause_irq_n = 1'b1;
            ext_irq     = 1'b1;
            state_n     = ENTRY;
          end else if (bus.ERet) begin
            elr_n       = bus.PC;
            esr_n       = 4'b0100;
            cause_irq_n = 1'b0;
            state_n     = ENTRY;
          end
        end
      end
      ENTRY: begin
        exc     = 1'b1;
        irq_ack = cause_irq;
        state_n = HANDLER;
      end
      HANDLER: begin
        // An invalid opcode wins over ERET, matching the RUN-state priority.
        if (bus.instr_valid && bus.NotAnInstr) begin
          df_n        = 1'b1;
          esr_n       = bus.EStatus;
          cause_irq_n = 1'b0;
          state_n     = ENTRY;
        end else if (bus.instr_valid && bus.ERet) begin
          state_n = RET;
        end
      end
      RET: begin
        eret_taken = 1'b1;
        state_n    = RUN;
      end
      default: state_n = RUN;
    endcase
  end

  assign bus.ExtIRQ      = ext_irq;
  assign bus.IRQAck      = irq_ack;
  assign bus.Exc         = exc;
  assign bus.ERetTaken   = eret_taken;
  assign bus.ExcVector   = VECTOR;
  assign bus.ELR         = elr;
  assign bus.ESR         = esr;
  assign bus.DoubleFault = df;
  assign bus.InHandler   = (state == ENTRY) || (state == HANDLER);

  always_comb begin
    bus.sysreg_rdata = '0;
    case (bus.sysreg_sel)
      2'b00:   bus.sysreg_rdata = elr;
      2'b01:   bus.sysreg_rdata = {60'b0, esr};
      2'b10:   bus.sysreg_rdata = {61'b0, df, bus.InHandler, bus.IRQReq};
      default: bus.sysreg_rdata = '0;
    endcase
  end

endmodule
